cache_fill_ctl: RTL and testbench

CACHE_FILL_CTL -- requirements
Module: cache_fill_ctl

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_sweep_ctr.sv | 35 +++
 rtl/cache_fill_ctl.sv | 191 +++++++++++++++++++
 tb/tb_cache_fill_ctl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg
// Shared types and constants for the cache fill/invalidate/flush controller.
//   - cache_state_e : controller states
//   - INDEX_W/TAG_W : cache array index and tag widths
//   - INDEX_MSB/LSB, TAG_MSB/LSB : where index and tag sit in a 24-bit address
package cache_pkg;

  localparam int ADR_W     = 24;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int INDEX_W   = 10;
  localparam int TAG_W     = 12;
  localparam int INDEX_LSB = 2;
  localparam int INDEX_MSB = INDEX_LSB + INDEX_W - 1;  // 11
  localparam int TAG_LSB   = INDEX_MSB + 1;            // 12
  localparam int TAG_MSB   = TAG_LSB + TAG_W - 1;      // 23

  // Byte enables are active-low: all ones means no byte lane enabled.
  localparam logic [BE_W-1:0] BE_NONE_L = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_INVAL = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cache_sweep_ctr.sv
// cache_sweep_ctr
// Index counter for the whole-cache flush sweep.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset (count -> 0)
//   i_clr   : load zero (has priority over i_en)
//   i_en    : increment
//   o_count : current count
//   o_tc    : terminal count (count is the last index)
module cache_sweep_ctr
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [INDEX_W-1:0] o_count,
  output logic               o_tc
);

  logic [INDEX_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = &r_count;

endmodule

// File: rtl/cache_fill_ctl.sv
// cache_fill_ctl
// Cache array write controller: single-longword fills, single-line
// invalidates and a whole-cache flush sweep, all sharing one write port.
//
// Build option: CACHE_PWRUP_FLUSH_EN -- when defined the controller leaves
// reset in FLUSH and sweeps the whole array once; otherwise it leaves reset
// in IDLE.
//
// Ports
//   b_clk_l                 : clock, all state on rising edge
//   init_h                  : asynchronous active-high reset
//   flush_req_h             : 1-cycle pulse, invalidate whole cache
//   inval_req_h/inval_adr_h : invalidate one line, held until inval_ack_h
//   fill_req_h/fill_adr_h/fill_data_h/fill_be_l : fill request (level),
//                             transfers when fill_req_h & fill_rdy_h
//   fill_rdy_h              : controller can accept a fill this cycle
//   inval_ack_h             : invalidate performed (1 cycle)
//   flush_done_h            : flush sweep complete (1 cycle)
//   cache_grp0_wr_h, wr_index_h, wr_tag_h, cache_wdata_h, ena_byte_l,
//   cache_valid_0_h         : array write port
//   ca_hit_inh_h            : forces cache misses
//   busy_h                  : controller not idle
module cache_fill_ctl
  import cache_pkg::*;
(
  input  logic               b_clk_l,
  input  logic               init_h,
  input  logic               flush_req_h,
  input  logic               inval_req_h,
  input  logic [ADR_W-1:0]   inval_adr_h,
  input  logic               fill_req_h,
  input  logic [ADR_W-1:0]   fill_adr_h,
  input  logic [DATA_W-1:0]  fill_data_h,
  input  logic [BE_W-1:0]    fill_be_l,
  output logic               fill_rdy_h,
  output logic               inval_ack_h,
  output logic               flush_done_h,
  output logic               cache_grp0_wr_h,
  output logic [INDEX_W-1:0] wr_index_h,
  output logic [TAG_W-1:0]   wr_tag_h,
  output logic [DATA_W-1:0]  cache_wdata_h,
  output logic [BE_W-1:0]    ena_byte_l,
  output logic               cache_valid_0_h,
  output logic               ca_hit_inh_h,
  output logic               busy_h
);

`ifdef CACHE_PWRUP_FLUSH_EN
  localparam cache_state_e RST_STATE = ST_FLUSH;
`else
  localparam cache_state_e RST_STATE = ST_IDLE;
`endif

  cache_state_e       r_state, w_state_next;
  logic               r_flush_pend, w_flush_pend_next;
  logic               r_last;      // the write on the port now is the last sweep index
  logic               r_rdy;       // IDLE with no flush pending
  logic               r_wr, r_valid, r_ack, r_done, r_busy, r_hit_inh;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_wdata;
  logic [BE_W-1:0]    r_be_l;

  logic               w_wr_next, w_valid_next, w_ack_next, w_done_next;
  logic [INDEX_W-1:0] w_index_next;
  logic [TAG_W-1:0]   w_tag_next;
  logic [DATA_W-1:0]  w_wdata_next;
  logic [BE_W-1:0]    w_be_l_next;

  logic [INDEX_W-1:0] w_count;
  logic               w_tc, w_sweep_load, w_enter_flush, w_flush_any, w_xfer;
  logic               w_unused_adr_bits;

  // Only the index/tag fields of the addresses are used.
  assign w_unused_adr_bits = ^{inval_adr_h[ADR_W-1:INDEX_MSB+1], inval_adr_h[INDEX_LSB-1:0],
                               fill_adr_h[INDEX_LSB-1:0]};

  // The state-dependent part is registered; the request terms withdraw
  // readiness in the same cycle so a fill never races a flush/invalidate.
  assign fill_rdy_h  = r_rdy & ~flush_req_h & ~inval_req_h;
  assign w_xfer      = fill_req_h & fill_rdy_h;
  assign w_flush_any = r_flush_pend | flush_req_h;

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_flush_any)      w_state_next = ST_FLUSH;
        else if (inval_req_h) w_state_next = ST_INVAL;
        else if (w_xfer)      w_state_next = ST_FILL;
      end
      ST_FLUSH: if (r_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Every edge that keeps/enters FLUSH puts one more sweep index on the port.
  assign w_sweep_load      = (w_state_next == ST_FLUSH);
  assign w_enter_flush     = (r_state != ST_FLUSH) && w_sweep_load;
  // A flush request that arrives mid-sweep is remembered, not restarted.
  assign w_flush_pend_next = w_enter_flush ? 1'b0 : (r_flush_pend | flush_req_h);

  cache_sweep_ctr u_sweep_ctr (
    .i_clk   (b_clk_l),
    .i_rst   (init_h),
    .i_clr   (~w_sweep_load),
    .i_en    (w_sweep_load),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // Output values for the coming cycle, selected by the state being entered.
  always_comb begin
    w_wr_next    = 1'b0;
    w_index_next = '0;
    w_tag_next   = '0;
    w_wdata_next = '0;
    w_be_l_next  = BE_NONE_L;
    w_valid_next = 1'b0;
    w_ack_next   = 1'b0;
    w_done_next  = 1'b0;
    case (w_state_next)
      ST_FILL: begin
        w_wr_next    = 1'b1;
        w_index_next = fill_adr_h[INDEX_MSB:INDEX_LSB];
        w_tag_next   = fill_adr_h[TAG_MSB:TAG_LSB];
        w_wdata_next = fill_data_h;
        w_be_l_next  = fill_be_l;
        w_valid_next = 1'b1;
      end
      ST_INVAL: begin
        w_wr_next    = 1'b1;
        w_index_next = inval_adr_h[INDEX_MSB:INDEX_LSB];
        w_ack_next   = 1'b1;
      end
      ST_FLUSH: begin
        w_wr_next    = 1'b1;
        w_index_next = w_count;
      end
      default: w_done_next = (r_state == ST_FLUSH);
    endcase
  end

  always_ff @(posedge b_clk_l or posedge init_h) begin
    if (init_h) begin
      r_state      <= RST_STATE;
      r_flush_pend <= 1'b0;
      r_last       <= 1'b0;
      r_rdy        <= 1'b0;
      r_wr         <= 1'b0;
      r_index      <= '0;
      r_tag        <= '0;
      r_wdata      <= '0;
      r_be_l       <= BE_NONE_L;
      r_valid      <= 1'b0;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_hit_inh    <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_flush_pend <= w_flush_pend_next;
      r_last       <= w_sweep_load & w_tc;
      r_rdy        <= (w_state_next == ST_IDLE) & ~w_flush_pend_next;
      r_wr         <= w_wr_next;
      r_index      <= w_index_next;
      r_tag        <= w_tag_next;
      r_wdata      <= w_wdata_next;
      r_be_l       <= w_be_l_next;
      r_valid      <= w_valid_next;
      r_ack        <= w_ack_next;
      r_done       <= w_done_next;
      r_busy       <= (w_state_next != ST_IDLE);
      // Hits stay inhibited for one extra cycle once the done pulse has gone out.
      r_hit_inh    <= (w_state_next == ST_FLUSH) | (w_state_next == ST_FILL) | r_done;
    end
  end

  assign cache_grp0_wr_h = r_wr;
  assign wr_index_h      = r_index;
  assign wr_tag_h        = r_tag;
  assign cache_wdata_h   = r_wdata;
  assign ena_byte_l      = r_be_l;
  assign cache_valid_0_h = r_valid;
  assign inval_ack_h     = r_ack;
  assign flush_done_h    = r_done;
  assign busy_h          = r_busy;
  assign ca_hit_inh_h    = r_hit_inh;

endmodule

// File: tb/tb_cache_fill_ctl.sv
// tb_cache_fill_ctl
// Scoreboard bench: stimulus tasks push the expected array-port activity
// (fill, invalidate, sweep writes, done pulse) into a queue; a monitor on the
// falling clock edge pops and compares whenever the port writes or reports
// flush done, and checks the idle-bus, busy, ack and hit-inhibit rules every
// cycle. Define CACHE_PWRUP_FLUSH_EN for both bench and design to test the
// power-up sweep variant.
module tb_cache_fill_ctl;
  import cache_pkg::*;

  localparam int K_FILL  = 0;
  localparam int K_INVAL = 1;
  localparam int K_SWEEP = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int          kind;
    logic [9:0]  index;
    logic [11:0] tag;
    logic [31:0] data;
    logic [3:0]  be_l;
    logic        valid;
  } exp_t;

  logic        b_clk_l = 1'b0;
  logic        init_h = 1'b1;
  logic        flush_req_h = 1'b0;
  logic        inval_req_h = 1'b0;
  logic [23:0] inval_adr_h = '0;
  logic        fill_req_h = 1'b0;
  logic [23:0] fill_adr_h = '0;
  logic [31:0] fill_data_h = '0;
  logic [3:0]  fill_be_l = 4'b1111;
  logic        fill_rdy_h, inval_ack_h, flush_done_h, cache_grp0_wr_h;
  logic [9:0]  wr_index_h;
  logic [11:0] wr_tag_h;
  logic [31:0] cache_wdata_h;
  logic [3:0]  ena_byte_l;
  logic        cache_valid_0_h, ca_hit_inh_h, busy_h;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   prev_done = 0;
  bit   must_follow = 0;
  int   mon_kind;

  always #5 b_clk_l = ~b_clk_l;

  cache_fill_ctl dut (
    .b_clk_l(b_clk_l), .init_h(init_h), .flush_req_h(flush_req_h),
    .inval_req_h(inval_req_h), .inval_adr_h(inval_adr_h),
    .fill_req_h(fill_req_h), .fill_adr_h(fill_adr_h), .fill_data_h(fill_data_h),
    .fill_be_l(fill_be_l), .fill_rdy_h(fill_rdy_h), .inval_ack_h(inval_ack_h),
    .flush_done_h(flush_done_h), .cache_grp0_wr_h(cache_grp0_wr_h),
    .wr_index_h(wr_index_h), .wr_tag_h(wr_tag_h), .cache_wdata_h(cache_wdata_h),
    .ena_byte_l(ena_byte_l), .cache_valid_0_h(cache_valid_0_h),
    .ca_hit_inh_h(ca_hit_inh_h), .busy_h(busy_h)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: address fields by plain arithmetic on the byte address.
  function automatic void push_fill(logic [23:0] adr, logic [31:0] data, logic [3:0] be);
    exp_t e;
    e.kind = K_FILL; e.index = 10'((adr / 4) % 1024); e.tag = 12'(adr / 4096);
    e.data = data; e.be_l = be; e.valid = 1'b1;
    exp_q.push_back(e);
  endfunction

  function automatic void push_inval(logic [23:0] adr);
    exp_t e;
    e.kind = K_INVAL; e.index = 10'((adr / 4) % 1024); e.tag = '0;
    e.data = '0; e.be_l = 4'b1111; e.valid = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_sweep();
    exp_t e;
    for (int i = 0; i < 1024; i++) begin
      e.kind = K_SWEEP; e.index = 10'(i); e.tag = '0;
      e.data = '0; e.be_l = 4'b1111; e.valid = 1'b0;
      exp_q.push_back(e);
    end
    e.kind = K_DONE; e.index = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor
  initial forever begin
    @(negedge b_clk_l);
    if (!mon_en) begin
      prev_done = 0;
      must_follow = 0;
    end else begin
      mon_kind = -1;
      if (must_follow) chk("sweep_continuity", 64'(cache_grp0_wr_h | flush_done_h), 1);
      must_follow = 0;
      if (cache_grp0_wr_h || flush_done_h) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: wr=%b done=%b index=%h with nothing expected at %0t",
                   cache_grp0_wr_h, flush_done_h, wr_index_h, $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_kind = mon_e.kind;
          if (mon_e.kind == K_DONE) begin
            chk("done_pulse", {cache_grp0_wr_h, flush_done_h}, 2'b01);
            $display("txn flush_done at %0t", $time);
          end else begin
            chk("write_strobe", {cache_grp0_wr_h, flush_done_h}, 2'b10);
            chk("wr_index", wr_index_h, mon_e.index);
            chk("wr_tag", wr_tag_h, mon_e.tag);
            chk("wdata", cache_wdata_h, mon_e.data);
            chk("ena_byte_l", ena_byte_l, mon_e.be_l);
            chk("valid", cache_valid_0_h, mon_e.valid);
            chk("inval_ack", inval_ack_h, 64'(mon_e.kind == K_INVAL));
            must_follow = (mon_e.kind == K_SWEEP);
            if (mon_e.kind == K_FILL)
              $display("txn fill index=%h tag=%h data=%h be_l=%b", wr_index_h, wr_tag_h,
                       cache_wdata_h, ena_byte_l);
            else if (mon_e.kind == K_INVAL)
              $display("txn inval index=%h", wr_index_h);
          end
        end
      end else begin
        chk("idle_bus", {wr_index_h, wr_tag_h, cache_wdata_h, ena_byte_l, cache_valid_0_h, inval_ack_h},
            {10'd0, 12'd0, 32'd0, 4'b1111, 1'b0, 1'b0});
      end
      chk("busy", busy_h, cache_grp0_wr_h);
      chk("hit_inh", ca_hit_inh_h, 64'((cache_grp0_wr_h && mon_kind != K_INVAL) || prev_done));
      if (busy_h) chk("rdy_while_busy", fill_rdy_h, 0);
      prev_done = flush_done_h;
    end
  end

  task automatic wait_drain(int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge b_clk_l);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge b_clk_l);
  endtask

  task automatic do_fill(logic [23:0] adr, logic [31:0] data, logic [3:0] be);
    int n = 0;
    push_fill(adr, data, be);
    @(posedge b_clk_l); #1;
    fill_req_h = 1'b1; fill_adr_h = adr; fill_data_h = data; fill_be_l = be;
    do begin
      @(negedge b_clk_l);
      n++;
    end while (!fill_rdy_h && n < 5000);
    chk("fill_handshake", fill_rdy_h, 1);
    @(posedge b_clk_l); #1;
    fill_req_h = 1'b0;
    fill_adr_h = 24'($urandom); fill_data_h = $urandom; fill_be_l = 4'($urandom);
  endtask

  task automatic do_inval(logic [23:0] adr, bit with_fill, logic [23:0] fadr, logic [31:0] fdata);
    int n = 0;
    push_inval(adr);
    if (with_fill) push_fill(fadr, fdata, 4'b0000);
    @(posedge b_clk_l); #1;
    inval_req_h = 1'b1; inval_adr_h = adr;
    if (with_fill) begin
      fill_req_h = 1'b1; fill_adr_h = fadr; fill_data_h = fdata; fill_be_l = 4'b0000;
    end
    do begin
      @(negedge b_clk_l);
      n++;
      chk("rdy_during_inval_req", fill_rdy_h, 0);
    end while (!inval_ack_h && n < 5000);
    chk("inval_handshake", inval_ack_h, 1);
    @(posedge b_clk_l); #1;
    inval_req_h = 1'b0; inval_adr_h = 24'($urandom);
    if (with_fill) begin
      n = 0;
      do begin
        @(negedge b_clk_l);
        n++;
      end while (!fill_rdy_h && n < 5000);
      chk("fill_after_inval_handshake", fill_rdy_h, 1);
      @(posedge b_clk_l); #1;
      fill_req_h = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    @(posedge b_clk_l); #1;
    flush_req_h = 1'b1;
    @(posedge b_clk_l); #1;
    flush_req_h = 1'b0;
  endtask

  task automatic wait_index(logic [9:0] idx);
    int n = 0;
    do begin
      @(negedge b_clk_l);
      n++;
    end while (!(busy_h && cache_grp0_wr_h && wr_index_h == idx) && n < 3000);
    chk("reached_sweep_index", wr_index_h, idx);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while init_h is held.
    repeat (3) @(negedge b_clk_l);
    chk("rst_wr", cache_grp0_wr_h, 0);
    chk("rst_ena_byte_l", ena_byte_l, 4'b1111);
    chk("rst_bus", {wr_index_h, wr_tag_h, cache_wdata_h, cache_valid_0_h}, 0);
    chk("rst_ack_done", {inval_ack_h, flush_done_h}, 0);
    chk("rst_busy", busy_h, 0);
    chk("rst_fill_rdy", fill_rdy_h, 0);
    chk("rst_hit_inh", ca_hit_inh_h, 1);
    init_h = 1'b0;
`ifdef CACHE_PWRUP_FLUSH_EN
    push_sweep();
`endif
    #1 mon_en = 1;
`ifdef CACHE_PWRUP_FLUSH_EN
    wait_drain(1500);
`else
    repeat (5) @(negedge b_clk_l);
`endif

    // Directed fills.
    do_fill(24'hABC123, 32'hDEADBEEF, 4'b0000);
    do_fill(24'h123456, 32'h0BADF00D, 4'b1010);
    wait_drain(50);

    // Invalidate and fill requested together: invalidate goes first.
    do_inval(24'h0003FC, 1'b1, 24'hFFFFFC, 32'hCAFEF00D);
    wait_drain(50);

    // Randomized fills and invalidates.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        do_fill(24'($urandom), $urandom, 4'($urandom));
      else
        do_inval(24'($urandom), 1'b0, 24'h0, 32'h0);
      repeat ($urandom_range(0, 3)) @(posedge b_clk_l);
    end
    wait_drain(100);

    // Flush with a fill held waiting behind it.
    push_sweep();
    pulse_flush();
    do_fill(24'h5A5A5A, 32'h12345678, 4'b0110);
    wait_drain(1500);

    // Second flush request mid-sweep: exactly one more full sweep.
    push_sweep();
    push_sweep();
    pulse_flush();
    wait_index(10'd500);
    pulse_flush();
    wait_drain(3000);

    // Reset in the middle of a sweep.
    push_sweep();
    pulse_flush();
    wait_index(10'd300);
    mon_en = 0;
    #2 init_h = 1'b1;
    #1;
    chk("abort_wr", cache_grp0_wr_h, 0);
    chk("abort_busy", busy_h, 0);
    chk("abort_hit_inh", ca_hit_inh_h, 1);
    exp_q.delete();
    repeat (3) @(negedge b_clk_l);
    init_h = 1'b0;
`ifdef CACHE_PWRUP_FLUSH_EN
    push_sweep();
`endif
    #1 mon_en = 1;
`ifdef CACHE_PWRUP_FLUSH_EN
    wait_drain(1500);
`else
    repeat (10) @(negedge b_clk_l);
`endif
    do_fill(24'h000FFC, 32'hA5A5A5A5, 4'b1010);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
